// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch-stage program-counter generator.
// No logic here; consumed by pc_gen and redir_arb via import pc_gen_pkg::*.
// Optional macro PC_ALIGN_CHECK_EN is interpreted by the importing modules.
package pc_gen_pkg;

    // Fetch FSM: IDLE before start, RUN while fetching, HALT after WFI/ebreak.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Default instruction size and the matching count of forced-zero low PC bits.
    localparam int DEF_INST_BYTES = 4;
    localparam int ALIGN_BITS     = clog2(DEF_INST_BYTES);

endpackage

// File: rtl/redir_arb.sv
// Purpose: fixed-priority pick over N redirect channels plus one pending entry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the winner is loaded or captured.
// Optional PC_ALIGN_CHECK_EN: misaligned targets are skipped and flagged instead of truncated.
module redir_arb
    import pc_gen_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int N_REDIR = 3,
    parameter int IDX_W   = 2,
    parameter int ALIGN_W = ALIGN_BITS
) (
    input  logic [N_REDIR-1:0]      redir_valid,
    input  logic [N_REDIR*PC_W-1:0] redir_pc,
    input  logic                    pend_valid,
    input  logic [IDX_W-1:0]        pend_idx,
    input  logic [PC_W-1:0]         pend_pc,
    output logic                    win_valid,
    output logic [IDX_W-1:0]        win_idx,
`ifdef PC_ALIGN_CHECK_EN
    output logic                    win_misalign,
`endif
    output logic [PC_W-1:0]         win_pc
);

    localparam logic [PC_W-1:0] ONE      = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] LOW_MASK = (ONE << ALIGN_W) - ONE;

    logic                inc_vld;
    logic [IDX_W-1:0]    inc_idx;
    logic [PC_W-1:0]     inc_pc;
    logic                take_inc;
`ifdef PC_ALIGN_CHECK_EN
    logic                raw_vld;
    logic [IDX_W-1:0]    raw_idx;
    logic [PC_W-1:0]     raw_pc;
`endif

    // Lowest-index live channel; scanning downward lets the lowest index overwrite.
    always_comb begin
        inc_vld = 1'b0;
        inc_idx = '0;
        inc_pc  = '0;
`ifdef PC_ALIGN_CHECK_EN
        raw_vld = 1'b0;
        raw_idx = '0;
        raw_pc  = '0;
`endif
        for (int k = N_REDIR - 1; k >= 0; k--) begin
`ifdef PC_ALIGN_CHECK_EN
            if (redir_valid[k]) begin
                raw_vld = 1'b1;
                raw_idx = IDX_W'(k);
                raw_pc  = redir_pc[k*PC_W +: PC_W];
            end
            if (redir_valid[k] && ((redir_pc[k*PC_W +: PC_W] & LOW_MASK) == '0)) begin
`else
            if (redir_valid[k]) begin
`endif
                inc_vld = 1'b1;
                inc_idx = IDX_W'(k);
                inc_pc  = redir_pc[k*PC_W +: PC_W];
            end
        end
    end

    // Incoming channel wins ties against the pending entry of the same index.
    always_comb begin
        take_inc  = inc_vld && (!pend_valid || (inc_idx <= pend_idx));
        win_valid = inc_vld || pend_valid;
        win_idx   = take_inc ? inc_idx : pend_idx;
`ifdef PC_ALIGN_CHECK_EN
        win_pc    = take_inc ? inc_pc : pend_pc;
`else
        win_pc    = (take_inc ? inc_pc : pend_pc) & ~LOW_MASK;
`endif
    end

`ifdef PC_ALIGN_CHECK_EN
    // The top-priority request overall was a misaligned channel that got skipped.
    always_comb begin
        win_misalign = raw_vld && (!pend_valid || (raw_idx <= pend_idx))
                       && ((raw_pc & LOW_MASK) != '0);
    end
`endif

endmodule

// File: rtl/pc_gen.sv
// Purpose: fetch PC register with IDLE/RUN/HALT control and prioritised redirects.
// Latency: redirect with update enabled lands on pc_o next cycle; captured one lands a cycle after first update.
// Backpressure: stall_i/pc_write_i hold the PC; redirects seen meanwhile are captured in a single best-priority slot.
// Optional PC_ALIGN_CHECK_EN: adds misalign_o and skips misaligned targets instead of clearing their low bits.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_VEC  = '0,
    parameter int              INST_BYTES = 4,
    parameter int              N_REDIR    = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    stall_i,
    input  logic                    pc_write_i,
    input  logic                    halt_i,
    input  logic [N_REDIR-1:0]      redir_valid_i,
    input  logic [N_REDIR*PC_W-1:0] redir_pc_i,
    output logic [PC_W-1:0]         pc_o,
    output logic                    pc_valid_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic                    misalign_o,
`endif
    output logic                    redir_pending_o
);

    localparam int              ALIGN_W = clog2(INST_BYTES);
    localparam int              IDX_W   = (N_REDIR > 1) ? clog2(N_REDIR) : 1;
    localparam logic [PC_W-1:0] STEP    = PC_W'(INST_BYTES);

    pc_state_e        state_q;
    logic [PC_W-1:0]  pc_q;
    logic             pc_vld_q;
    logic             pend_vld_q;
    logic [IDX_W-1:0] pend_idx_q;
    logic [PC_W-1:0]  pend_pc_q;
    logic             upd;
    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [PC_W-1:0]  win_pc;
`ifdef PC_ALIGN_CHECK_EN
    logic             win_misalign;
    logic             mis_q;
`endif

    // Stall always overrides the hazard unit's write enable.
    assign upd = ~stall_i & pc_write_i;

    redir_arb #(
        .PC_W    (PC_W),
        .N_REDIR (N_REDIR),
        .IDX_W   (IDX_W),
        .ALIGN_W (ALIGN_W)
    ) u_redir_arb (
        .redir_valid  (redir_valid_i),
        .redir_pc     (redir_pc_i),
        .pend_valid   (pend_vld_q),
        .pend_idx     (pend_idx_q),
        .pend_pc      (pend_pc_q),
        .win_valid    (win_valid),
        .win_idx      (win_idx),
`ifdef PC_ALIGN_CHECK_EN
        .win_misalign (win_misalign),
`endif
        .win_pc       (win_pc)
    );

    // FSM, PC register and single-entry pending redirect slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pc_q       <= RESET_VEC;
            pc_vld_q   <= 1'b0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            pend_pc_q  <= '0;
`ifdef PC_ALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            mis_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    // RESET_VEC is the first fetch address, so the PC is not advanced on start.
                    pc_q <= RESET_VEC;
                    if (start_i) begin
                        state_q  <= RUN;
                        pc_vld_q <= 1'b1;
                    end
                end
                RUN: begin
`ifdef PC_ALIGN_CHECK_EN
                    mis_q <= win_misalign;
`endif
                    if (upd) begin
                        pend_vld_q <= 1'b0;
                        if (win_valid) begin
                            // A redirect outranks a simultaneous halt.
                            pc_q <= win_pc;
                        end else begin
                            pc_q <= pc_q + STEP;
                            if (halt_i) begin
                                state_q  <= HALT;
                                pc_vld_q <= 1'b0;
                            end
                        end
                    end else if (win_valid) begin
                        // The winner already accounts for the current pending entry.
                        pend_vld_q <= 1'b1;
                        pend_idx_q <= win_idx;
                        pend_pc_q  <= win_pc;
                    end
                end
                HALT: begin
`ifdef PC_ALIGN_CHECK_EN
                    mis_q <= win_misalign;
`endif
                    if (upd) begin
                        pend_vld_q <= 1'b0;
                        if (win_valid) begin
                            pc_q     <= win_pc;
                            state_q  <= RUN;
                            pc_vld_q <= 1'b1;
                        end
                    end else if (win_valid) begin
                        pend_vld_q <= 1'b1;
                        pend_idx_q <= win_idx;
                        pend_pc_q  <= win_pc;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    pc_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = pc_vld_q;
    assign redir_pending_o = pend_vld_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_o      = mis_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed stimulus pushes expected outputs into a scoreboard queue.
// A monitor pops and compares two time units after every rising edge.
// A second narrow instance (PC_W=8) exercises silent wrap-around.
module tb_pc_gen;

    typedef struct {
        logic [31:0] pc;
        logic        vld;
        logic        pend;
        logic        mis;
        bit          dut;
        string       nm;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        stall_i;
    logic        pc_write_i;
    logic        halt_i;
    logic [2:0]  redir_valid_i;
    logic [95:0] redir_pc_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        redir_pending_o;

    logic        w_start_i;
    logic        w_stall_i;
    logic        w_pc_write_i;
    logic        w_halt_i;
    logic [0:0]  w_redir_valid_i;
    logic [7:0]  w_redir_pc_i;
    logic [7:0]  w_pc_o;
    logic        w_pc_valid_o;
    logic        w_redir_pending_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign_o;
    logic        w_misalign_o;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    pc_gen #(.PC_W(32), .RESET_VEC(32'h0), .INST_BYTES(4), .N_REDIR(3)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .pc_write_i      (pc_write_i),
        .halt_i          (halt_i),
        .redir_valid_i   (redir_valid_i),
        .redir_pc_i      (redir_pc_i),
        .pc_o            (pc_o),
        .pc_valid_o      (pc_valid_o),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_o      (misalign_o),
`endif
        .redir_pending_o (redir_pending_o)
    );

    pc_gen #(.PC_W(8), .RESET_VEC(8'hF4), .INST_BYTES(4), .N_REDIR(1)) dut_w (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (w_start_i),
        .stall_i         (w_stall_i),
        .pc_write_i      (w_pc_write_i),
        .halt_i          (w_halt_i),
        .redir_valid_i   (w_redir_valid_i),
        .redir_pc_i      (w_redir_pc_i),
        .pc_o            (w_pc_o),
        .pc_valid_o      (w_pc_valid_o),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_o      (w_misalign_o),
`endif
        .redir_pending_o (w_redir_pending_o)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic check_exp(input exp_t e);
        if (!e.dut) begin
            cmp({e.nm, ".pc"},   pc_o, e.pc);
            cmp({e.nm, ".vld"},  32'(pc_valid_o), 32'(e.vld));
            cmp({e.nm, ".pend"}, 32'(redir_pending_o), 32'(e.pend));
`ifdef PC_ALIGN_CHECK_EN
            cmp({e.nm, ".mis"},  32'(misalign_o), 32'(e.mis));
`endif
        end else begin
            cmp({e.nm, ".pc"},   32'(w_pc_o), e.pc);
            cmp({e.nm, ".vld"},  32'(w_pc_valid_o), 32'(e.vld));
            cmp({e.nm, ".pend"}, 32'(w_redir_pending_o), 32'(e.pend));
`ifdef PC_ALIGN_CHECK_EN
            cmp({e.nm, ".mis"},  32'(w_misalign_o), 32'(e.mis));
`endif
        end
    endtask

    // Monitor: every expectation queued for this cycle is compared after the edge settles.
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            while (sb.size() > 0) begin
                check_exp(sb.pop_front());
            end
        end
    end

    // One clock of main-instance stimulus; expected outputs after the edge go to the scoreboard.
    task automatic cyc(input logic st, input logic sl, input logic pw, input logic hl,
                       input logic [2:0] rv, input logic [31:0] t0, input logic [31:0] t1,
                       input logic [31:0] t2, input logic [31:0] epc, input logic evld,
                       input logic epend, input string nm, input logic emis = 1'b0);
        exp_t e;
        start_i       = st;
        stall_i       = sl;
        pc_write_i    = pw;
        halt_i        = hl;
        redir_valid_i = rv;
        redir_pc_i    = {t2, t1, t0};
        @(posedge clk_i);
        #1;
        e.pc = epc; e.vld = evld; e.pend = epend; e.mis = emis; e.dut = 1'b0; e.nm = nm;
        sb.push_back(e);
    endtask

    // One clock of narrow-instance stimulus.
    task automatic wcyc(input logic st, input logic [31:0] epc, input logic evld, input string nm);
        exp_t e;
        w_start_i = st;
        @(posedge clk_i);
        #1;
        e.pc = epc; e.vld = evld; e.pend = 1'b0; e.mis = 1'b0; e.dut = 1'b1; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        rst_i = 1'b0; start_i = 1'b0; stall_i = 1'b0; pc_write_i = 1'b1; halt_i = 1'b0;
        redir_valid_i = '0; redir_pc_i = '0;
        w_start_i = 1'b0; w_stall_i = 1'b0; w_pc_write_i = 1'b1; w_halt_i = 1'b0;
        w_redir_valid_i = '0; w_redir_pc_i = '0;
        #2 rst_i = 1'b1;

        //   st sl pw hl rv      ch0           ch1           ch2           exp pc        vld pend name
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, "reset");
        rst_i = 1'b0;
        cyc(0, 0, 1, 0, 3'b001, 32'h700,      32'h0,        32'h0,        32'h0,        0, 0, "idle_ignore");
        cyc(0, 1, 1, 0, 3'b001, 32'h700,      32'h0,        32'h0,        32'h0,        0, 0, "idle_nocap");
        cyc(1, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, "start");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h4,        1, 0, "seq4");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h8,        1, 0, "seq8");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'hC,        1, 0, "seq12");
        cyc(0, 0, 1, 0, 3'b001, 32'h100,      32'h0,        32'h0,        32'h100,      1, 0, "redir_ch0");
        cyc(0, 0, 1, 0, 3'b101, 32'h200,      32'h0,        32'h400,      32'h200,      1, 0, "prio_0_over_2");
        cyc(0, 0, 1, 0, 3'b001, 32'h40,       32'h0,        32'h0,        32'h40,       1, 0, "to_40");
        cyc(0, 1, 1, 0, 3'b010, 32'h0,        32'h800,      32'h0,        32'h40,       1, 1, "stall_cap");
        cyc(0, 1, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h40,       1, 1, "stall_hold");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h800,      1, 0, "pend_release");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h804,      1, 0, "after_pend");
        cyc(0, 1, 1, 0, 3'b010, 32'h0,        32'h800,      32'h0,        32'h804,      1, 1, "cap_ch1");
        cyc(0, 1, 1, 0, 3'b001, 32'h900,      32'h0,        32'h0,        32'h804,      1, 1, "cap_ch0_up");
        cyc(0, 1, 1, 0, 3'b100, 32'h0,        32'h0,        32'hA00,      32'h804,      1, 1, "cap_ch2_low");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h900,      1, 0, "release_best");
        cyc(0, 1, 1, 0, 3'b010, 32'h0,        32'h800,      32'h0,        32'h900,      1, 1, "cap_eq");
        cyc(0, 0, 1, 0, 3'b010, 32'h0,        32'h880,      32'h0,        32'h880,      1, 0, "inc_beats_eq_pend");
        cyc(0, 1, 1, 0, 3'b001, 32'h300,      32'h0,        32'h0,        32'h880,      1, 1, "cap_ch0");
        cyc(0, 0, 1, 0, 3'b100, 32'h0,        32'h0,        32'h500,      32'h300,      1, 0, "pend_beats_ch2");
        cyc(0, 0, 0, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h300,      1, 0, "pcw_low_hold");
        cyc(0, 1, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h300,      1, 0, "stall_dominates");
        cyc(1, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h304,      1, 0, "run_ignores_start");
`ifdef PC_ALIGN_CHECK_EN
        cyc(0, 0, 1, 0, 3'b001, 32'h102,      32'h0,        32'h0,        32'h308,      1, 0, "misalign_skip", 1'b1);
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h30C,      1, 0, "misalign_pulse", 1'b0);
        cyc(0, 0, 1, 0, 3'b011, 32'h102,      32'h600,      32'h0,        32'h600,      1, 0, "misalign_next", 1'b1);
`else
        cyc(0, 0, 1, 0, 3'b001, 32'h102,      32'h0,        32'h0,        32'h100,      1, 0, "low_bits_clear");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h104,      1, 0, "after_clear");
        cyc(0, 0, 1, 0, 3'b010, 32'h0,        32'h603,      32'h0,        32'h600,      1, 0, "low_bits_clear1");
`endif
        cyc(0, 0, 1, 0, 3'b001, 32'h10,       32'h0,        32'h0,        32'h10,       1, 0, "to_10");
        cyc(0, 0, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h14,       0, 0, "halt");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h14,       0, 0, "halt_hold");
        cyc(1, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h14,       0, 0, "halt_no_start");
        cyc(0, 0, 1, 0, 3'b001, 32'h1000,     32'h0,        32'h0,        32'h1000,     1, 0, "halt_exit");
        cyc(0, 0, 1, 1, 3'b010, 32'h0,        32'h2000,     32'h0,        32'h2000,     1, 0, "halt_vs_redir");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h2004,     1, 0, "still_run");
        cyc(0, 0, 1, 1, 3'b000, 32'h0,        32'h0,        32'h0,        32'h2008,     0, 0, "halt2");
        cyc(0, 1, 1, 0, 3'b100, 32'h0,        32'h0,        32'h3000,     32'h2008,     0, 1, "halt_cap");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h3000,     1, 0, "halt_pend_exit");
        cyc(0, 1, 1, 0, 3'b001, 32'h50,       32'h0,        32'h0,        32'h3000,     1, 1, "cap_pre_rst");

        // Asynchronous reset between edges must clear state without waiting for a clock.
        #2 rst_i = 1'b1;
        #1;
        e.pc = 32'h0; e.vld = 1'b0; e.pend = 1'b0; e.mis = 1'b0; e.dut = 1'b0; e.nm = "async_rst";
        check_exp(e);
        cyc(0, 1, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, "rst_held");
        rst_i = 1'b0;
        cyc(1, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h0,        1, 0, "restart");
        cyc(0, 0, 1, 0, 3'b000, 32'h0,        32'h0,        32'h0,        32'h4,        1, 0, "no_stale_pend");

        // Narrow instance: F4 -> F8 -> FC -> 00 wraps silently.
        wcyc(1, 32'hF4, 1, "w_start");
        wcyc(0, 32'hF8, 1, "w_f8");
        wcyc(0, 32'hFC, 1, "w_fc");
        wcyc(0, 32'h00, 1, "w_wrap");
        wcyc(0, 32'h04, 1, "w_04");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk_i);
        end
        #3;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
